// File: rtl/comp_2bit.sv
// comp_2bit: registered 2-bit unsigned magnitude comparator built from two 1-bit cells.
// COMP_2BIT_INPUT_REG_EN adds an operand register stage (latency 2 instead of 1).
module comp_2bit (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] A,
  input  logic [1:0] B,
  output logic       E2,
  output logic       G2,
  output logic       L2
);
  logic [1:0] a, b, e, g, l;
  logic v;
`ifdef COMP_2BIT_INPUT_REG_EN
  // v keeps the outputs at zero until the operand register holds a real sample
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      a <= '0;
      b <= '0;
      v <= 1'b0;
    end else begin
      a <= A;
      b <= B;
      v <= 1'b1;
    end
`else
  assign a = A;
  assign b = B;
  assign v = 1'b1;
`endif
  for (genvar i = 0; i < 2; i++) begin : g_cell
    assign e[i] = ~(a[i] ^ b[i]);
    assign g[i] = a[i] & ~b[i];
    assign l[i] = ~a[i] & b[i];
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      E2 <= 1'b0;
      G2 <= 1'b0;
      L2 <= 1'b0;
    end else begin
      E2 <= v & e[1] & e[0];
      G2 <= v & (g[1] | (e[1] & g[0]));
      L2 <= v & (l[1] | (e[1] & l[0]));
    end
endmodule

// File: tb/tb_comp_2bit.sv
// tb_comp_2bit: directed and random checks of comp_2bit against an integer-compare model.
module tb_comp_2bit;
`ifdef COMP_2BIT_INPUT_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [1:0] A = '0, B = '0;
  logic E2, G2, L2;
  int compared = 0, mismatched = 0;
  logic [3:0] hist[$];

  comp_2bit dut (.clk(clk), .rst_n(rst_n), .A(A), .B(B), .E2(E2), .G2(G2), .L2(L2));

  always #5 clk = ~clk;

  function automatic logic [2:0] model_cmp(input logic [3:0] ab);
    int x = int'(ab[3:2]);
    int y = int'(ab[1:0]);
    return {x == y, x > y, x < y};
  endfunction

  task automatic check(input string tag);
    int n = hist.size();
    logic [2:0] exp = (n < LAT) ? 3'b000 : model_cmp(hist[n-LAT]);
    compared++;
    assert ({E2, G2, L2} === exp) else begin
      mismatched++;
      $error("FAIL %s: EGL observed=%b expected=%b", tag, {E2, G2, L2}, exp);
    end
    if (n >= LAT) begin
      compared++;
      assert ($countones({E2, G2, L2}) == 1) else begin
        mismatched++;
        $error("FAIL %s_onehot: EGL observed=%b expected exactly one bit", tag, {E2, G2, L2});
      end
    end
  endtask

  task automatic step(input logic [1:0] a, input logic [1:0] b, input string tag);
    A = a;
    B = b;
    @(posedge clk);
    if (rst_n) hist.push_back({a, b});
    #1 check(tag);
  endtask

  initial begin
    #3 check("por");
    step(2'd3, 2'd1, "in_reset");
    step(2'd0, 2'd0, "in_reset");
    @(negedge clk) rst_n = 1'b1;
    for (int i = 0; i < 16; i++)
      for (int k = 0; k <= LAT; k++) step(2'(i >> 2), 2'(i), "sweep");
    repeat (3) step(2'd0, 2'd0, "lat_eq");
    repeat (3) step(2'd3, 2'd0, "lat_gt");
    repeat (LAT + 1) step(2'd2, 2'd1, "msb_gt");
    repeat (LAT + 1) step(2'd1, 2'd2, "msb_lt");
    step(2'd1, 2'd1, "b2b");
    step(2'd2, 2'd3, "b2b");
    step(2'd3, 2'd2, "b2b");
    repeat (LAT) step(2'd3, 2'd2, "b2b");
    repeat (3) step(2'd3, 2'd1, "pre_rst");
    #2 rst_n = 1'b0;
    hist.delete();
    #1 check("async_rst");
    step(2'd3, 2'd1, "held_rst");
    step(2'd3, 2'd1, "held_rst");
    @(negedge clk) rst_n = 1'b1;
    repeat (LAT + 2) step(2'd3, 2'd1, "post_rst");
    repeat (200) step(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), "rand");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
